// File: rtl/loader_pkg.sv
// Shared types for the UART instruction loader: framing FSM states, RX bit-timer states
// and the frame sync byte.
package loader_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_e;

endpackage

// File: rtl/instr_loader_uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start-bit qualification at half a bit,
// centre sampling of data and stop bits.
//
// state    | meaning
// RX_IDLE  | line idle, waiting for a falling edge
// RX_START | timing to mid start bit, re-checking it is still low
// RX_DATA  | sampling 8 data bits LSB first at bit centres
// RX_STOP  | sampling stop bit; high -> rx_valid, low -> rx_frame_err
module uart_rx
    import loader_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       rx_frame_err
);

    localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e   st_q, st_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  bits_q, bits_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte_q, byte_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        meta_q, meta_d;
    logic        sync_q, sync_d;
    logic        prev_q, prev_d;

    always_comb begin
        meta_d  = rx_in;
        sync_d  = meta_q;
        prev_d  = sync_q;
        st_d    = st_q;
        cnt_d   = cnt_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (st_q)
            RX_IDLE: begin
                if (prev_q && !sync_q) begin
                    st_d  = RX_START;
                    cnt_d = HALF_LOAD;
                end
            end
            RX_START: begin
                if (cnt_q == '0) begin
                    if (!sync_q) begin
                        st_d   = RX_DATA;
                        cnt_d  = FULL_LOAD;
                        bits_d = 3'd7;
                    end else begin
                        st_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {sync_q, shift_q[7:1]};
                    cnt_d   = FULL_LOAD;
                    if (bits_q == 3'd0) begin
                        st_d = RX_STOP;
                    end else begin
                        bits_d = bits_q - 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == '0) begin
                    st_d = RX_IDLE;
                    if (sync_q) begin
                        valid_d = 1'b1;
                        byte_d  = shift_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            prev_q  <= 1'b1;
            st_q    <= RX_IDLE;
            cnt_q   <= '0;
            bits_q  <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            meta_q  <= meta_d;
            sync_q  <= sync_d;
            prev_q  <= prev_d;
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_valid     = valid_q;
    assign rx_byte      = byte_q;
    assign rx_frame_err = ferr_q;

endmodule

// File: rtl/instr_loader.sv
// UART boot loader: parses SYNC/LEN/words/CSUM frames, writes words to instruction
// memory and releases the core reset only after a checksum-verified load.
//
// state   | meaning
// ST_IDLE | waiting for sync byte, other bytes ignored
// ST_LEN0 | expecting low byte of word count
// ST_LEN1 | expecting high byte of word count, range check
// ST_DATA | assembling little-endian words, one write per 4 bytes
// ST_CSUM | comparing received checksum with running XOR
// ST_DONE | load good, core released, RX ignored until reset
// ST_ERR  | load failed, core held, sync byte restarts a frame
module instr_loader
    import loader_pkg::*;
#(
    parameter int unsigned CLK_HZ         = 100000000,
    parameter int unsigned BAUD           = 115200,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_WORDS      = 1024,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    output logic        mem_w_en,
    output logic [31:0] mem_w_addr,
    output logic [31:0] mem_w_data,
    output logic        core_rst_n,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES);

    logic       rx_valid;
    logic [7:0] rx_byte;
    logic       rx_frame_err;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_in       (uart_rx),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .rx_frame_err(rx_frame_err)
    );

    ld_state_e     state_q, state_d;
    logic [15:0]   len_q, len_d;
    logic [15:0]   word_idx_q, word_idx_d;
    logic [1:0]    byte_idx_q, byte_idx_d;
    logic [31:0]   word_q, word_d;
    logic [7:0]    csum_q, csum_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          mem_w_en_q, mem_w_en_d;
    logic [31:0]   mem_w_addr_q, mem_w_addr_d;
    logic [31:0]   mem_w_data_q, mem_w_data_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          core_rst_n_q, core_rst_n_d;

    logic        rx_sync;
    logic        in_frame;
    logic        go_err;
    logic [15:0] len_full;

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
        csum_d       = csum_q;
        tmo_d        = tmo_q;
        mem_w_en_d   = 1'b0;
        mem_w_addr_d = mem_w_addr_q;
        mem_w_data_d = mem_w_data_q;
        busy_d       = busy_q;
        done_d       = done_q;
        err_d        = err_q;
        core_rst_n_d = core_rst_n_q;
        go_err       = 1'b0;
        len_full     = {rx_byte, len_q[7:0]};
        rx_sync      = rx_valid && (rx_byte == SYNC_BYTE);
        in_frame     = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                       (state_q == ST_DATA) || (state_q == ST_CSUM);

        case (state_q)
            ST_IDLE, ST_ERR: begin
                if (rx_sync) begin
                    state_d    = ST_LEN0;
                    busy_d     = 1'b1;
                    err_d      = 1'b0;
                    csum_d     = '0;
                    word_idx_d = '0;
                    byte_idx_d = '0;
                end
            end
            ST_LEN0: begin
                if (rx_valid) begin
                    len_d   = {8'h00, rx_byte};
                    csum_d  = csum_q ^ rx_byte;
                    state_d = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (rx_valid) begin
                    len_d  = len_full;
                    csum_d = csum_q ^ rx_byte;
                    if (32'(len_full) > MAX_WORDS) begin
                        go_err = 1'b1;
                    end else if (len_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid) begin
                    word_d[8*byte_idx_q +: 8] = rx_byte;
                    csum_d     = csum_q ^ rx_byte;
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        mem_w_en_d   = 1'b1;
                        mem_w_addr_d = BASE_ADDR + 32'({word_idx_q, 2'b00});
                        mem_w_data_d = {rx_byte, word_q[23:0]};
                        word_idx_d   = word_idx_q + 16'd1;
                        if (word_idx_q == len_q - 16'd1) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (rx_valid) begin
                    if (rx_byte == csum_q) begin
                        state_d      = ST_DONE;
                        done_d       = 1'b1;
                        busy_d       = 1'b0;
                        core_rst_n_d = 1'b1;
                    end else begin
                        go_err = 1'b1;
                    end
                end
            end
            default: ;
        endcase

        // Timeout runs only inside a frame; every received byte reloads it.
        if (rx_valid) begin
            tmo_d = TMO_LOAD;
        end else if (in_frame) begin
            if (tmo_q <= TW'(1)) begin
                go_err = 1'b1;
            end else begin
                tmo_d = tmo_q - TW'(1);
            end
        end

        if (rx_frame_err && (state_q != ST_DONE)) begin
            go_err = 1'b1;
        end

        if (go_err) begin
            state_d = ST_ERR;
            err_d   = 1'b1;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
            csum_q       <= '0;
            tmo_q        <= '0;
            mem_w_en_q   <= 1'b0;
            mem_w_addr_q <= BASE_ADDR;
            mem_w_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
            csum_q       <= csum_d;
            tmo_q        <= tmo_d;
            mem_w_en_q   <= mem_w_en_d;
            mem_w_addr_q <= mem_w_addr_d;
            mem_w_data_q <= mem_w_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            core_rst_n_q <= core_rst_n_d;
        end
    end

    assign mem_w_en   = mem_w_en_q;
    assign mem_w_addr = mem_w_addr_q;
    assign mem_w_data = mem_w_data_q;
    assign core_rst_n = core_rst_n_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: drives 8N1 frames at 10 clocks per bit and
// checks memory writes and status outputs against hand-computed values.
module tb_instr_loader;

    logic        clk;
    logic        rst_n;
    logic        uart_rx;
    logic        mem_w_en;
    logic [31:0] mem_w_addr;
    logic [31:0] mem_w_data;
    logic        core_rst_n;
    logic        busy;
    logic        done;
    logic        err;

    int errors = 0;
    int checks = 0;

    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    // Good-frame checksum: 02^00^78^56^34^12^EF^BE^AD^DE
    localparam logic [7:0] GOOD_CS = 8'h28;

    instr_loader #(
        .CLK_HZ        (1000000),
        .BAUD          (100000),
        .BASE_ADDR     (32'h0000_0000),
        .MAX_WORDS     (16),
        .TIMEOUT_CYCLES(500)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .mem_w_en  (mem_w_en),
        .mem_w_addr(mem_w_addr),
        .mem_w_data(mem_w_data),
        .core_rst_n(core_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_w_en) begin
            wr_addr.push_back(mem_w_addr);
            wr_data.push_back(mem_w_data);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (10) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    task automatic send_payload(input logic [7:0] cs);
        logic [7:0] body [10];
        body = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        for (int i = 0; i < 10; i++) send_byte(body[i]);
        send_byte(cs);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        uart_rx = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
    endtask

    task automatic test_reset();
        uart_rx = 1'b1;
        rst_n   = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mem_w_en !== 1'b0) begin errors++; $display("FAIL reset_mem_w_en got=%b exp=0", mem_w_en); end
        checks++; if (mem_w_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", mem_w_addr); end
        checks++; if (mem_w_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", mem_w_data); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL reset_core_rst_n got=%b exp=0", core_rst_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_good_load();
        logic [7:0] body [10];
        apply_reset();
        body = '{8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_byte(8'hA5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_after_sync got=%b exp=1", busy); end
        for (int i = 0; i < 10; i++) send_byte(body[i]);
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL good_core_held_before_csum got=%b exp=0", core_rst_n); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL good_done_before_csum got=%b exp=0", done); end
        send_byte(GOOD_CS);
        checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL good_write_count got=%0d exp=2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            checks++; if (wr_addr[0] !== 32'h0) begin errors++; $display("FAIL good_addr0 got=%h exp=00000000", wr_addr[0]); end
            checks++; if (wr_data[0] !== 32'h12345678) begin errors++; $display("FAIL good_data0 got=%h exp=12345678", wr_data[0]); end
            checks++; if (wr_addr[1] !== 32'h4) begin errors++; $display("FAIL good_addr1 got=%h exp=00000004", wr_addr[1]); end
            checks++; if (wr_data[1] !== 32'hDEADBEEF) begin errors++; $display("FAIL good_data1 got=%h exp=deadbeef", wr_data[1]); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL good_done got=%b exp=1", done); end
        checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL good_core_rst_n got=%b exp=1", core_rst_n); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_after got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL good_err got=%b exp=0", err); end
        // DONE must ignore a fresh frame.
        send_byte(8'hA5);
        send_payload(GOOD_CS);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_ignores_busy got=%b exp=0", busy); end
        checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL done_ignores_writes got=%0d exp=2", wr_addr.size()); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_sticky got=%b exp=1", done); end
    endtask

    task automatic test_bad_csum();
        apply_reset();
        send_byte(8'hA5);
        send_payload(GOOD_CS ^ 8'h01);
        checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL badcs_write_count got=%0d exp=2", wr_addr.size()); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL badcs_err got=%b exp=1", err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL badcs_done got=%b exp=0", done); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL badcs_core_rst_n got=%b exp=0", core_rst_n); end
        send_byte(8'hA5);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL retry_err_cleared got=%b exp=0", err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL retry_busy got=%b exp=1", busy); end
        send_payload(GOOD_CS);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL retry_done got=%b exp=1", done); end
        checks++; if (core_rst_n !== 1'b1) begin errors++; $display("FAIL retry_core_rst_n got=%b exp=1", core_rst_n); end
        checks++; if (wr_addr.size() !== 4) begin errors++; $display("FAIL retry_write_count got=%0d exp=4", wr_addr.size()); end
        if (wr_addr.size() == 4) begin
            checks++; if (wr_addr[2] !== 32'h0) begin errors++; $display("FAIL retry_addr2 got=%h exp=00000000", wr_addr[2]); end
            checks++; if (wr_data[3] !== 32'hDEADBEEF) begin errors++; $display("FAIL retry_data3 got=%h exp=deadbeef", wr_data[3]); end
        end
    endtask

    task automatic test_garbage();
        logic [7:0] junk [3];
        apply_reset();
        junk = '{8'h00, 8'hFF, 8'h3C};
        for (int i = 0; i < 3; i++) begin
            send_byte(junk[i]);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL garbage_busy idx=%0d got=%b exp=0", i, busy); end
        end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL garbage_err got=%b exp=0", err); end
        send_byte(8'hA5);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL garbage_sync_busy got=%b exp=1", busy); end
        send_payload(GOOD_CS);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL garbage_done got=%b exp=1", done); end
        checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL garbage_write_count got=%0d exp=2", wr_addr.size()); end
    endtask

    task automatic test_len_overflow();
        apply_reset();
        send_byte(8'hA5);
        send_byte(8'h11);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL lenovf_err_early got=%b exp=0", err); end
        send_byte(8'h00);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL lenovf_err got=%b exp=1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lenovf_busy got=%b exp=0", busy); end
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL lenovf_no_write got=%0d exp=0", wr_addr.size()); end
        checks++; if (core_rst_n !== 1'b0) begin errors++; $display("FAIL lenovf_core_rst_n got=%b exp=0", core_rst_n); end
    endtask

    task automatic test_timeout();
        apply_reset();
        send_byte(8'hA5);
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h78);
        send_byte(8'h56);
        repeat (400) @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_early got=%b exp=0", err); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL timeout_busy_early got=%b exp=1", busy); end
        repeat (200) @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL timeout_err got=%b exp=1", err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL timeout_busy got=%b exp=0", busy); end
        checks++; if (wr_addr.size() !== 0) begin errors++; $display("FAIL timeout_no_write got=%0d exp=0", wr_addr.size()); end
    endtask

    task automatic test_reset_mid_data();
        logic [7:0] part [8];
        apply_reset();
        part = '{8'hA5, 8'h02, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hEF};
        for (int i = 0; i < 8; i++) send_byte(part[i]);
        checks++; if (mem_w_data !== 32'h12345678) begin errors++; $display("FAIL middata_first_word got=%h exp=12345678", mem_w_data); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mem_w_data !== 32'h0) begin errors++; $display("FAIL middata_rst_data got=%h exp=0", mem_w_data); end
        checks++; if (mem_w_addr !== 32'h0) begin errors++; $display("FAIL middata_rst_addr got=%h exp=0", mem_w_addr); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL middata_rst_busy got=%b exp=0", busy); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL middata_rst_err got=%b exp=0", err); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        wr_addr.delete();
        wr_data.delete();
        send_byte(8'hA5);
        send_payload(GOOD_CS);
        checks++; if (wr_addr.size() !== 2) begin errors++; $display("FAIL middata_write_count got=%0d exp=2", wr_addr.size()); end
        if (wr_addr.size() == 2) begin
            checks++; if (wr_addr[0] !== 32'h0) begin errors++; $display("FAIL middata_addr0 got=%h exp=00000000", wr_addr[0]); end
            checks++; if (wr_data[0] !== 32'h12345678) begin errors++; $display("FAIL middata_data0 got=%h exp=12345678", wr_data[0]); end
        end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL middata_done got=%b exp=1", done); end
    endtask

    initial begin
        rst_n   = 1'b0;
        uart_rx = 1'b1;
        test_reset();
        test_good_load();
        test_bad_csum();
        test_garbage();
        test_len_overflow();
        test_timeout();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
